// File: rtl/line_fill_arbiter.sv
// Round-robin line-fill arbiter: shares one burst memory read port among NUM_CORES caches.
// Define CRITICAL_WORD_FIRST_EN to request the missed word first and wrap around the line.
module line_fill_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int DATA_SIZE      = 32,
    parameter int WORDS_PER_LINE = 8,
    parameter int OFFSET         = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CORES-1:0]           core_req,
    input  logic [NUM_CORES*DATA_SIZE-1:0] core_addr,
    output logic [NUM_CORES-1:0]           core_gnt,
    output logic [DATA_SIZE-1:0]           core_rdata,
    output logic [NUM_CORES-1:0]           core_rvalid,
    output logic [2:0]                     core_widx,
    output logic [NUM_CORES-1:0]           core_done,
    output logic                           mem_req,
    output logic [DATA_SIZE-1:0]           mem_addr,
    input  logic                           mem_ack,
    input  logic                           mem_rvalid,
    input  logic [DATA_SIZE-1:0]           mem_rdata
);

    localparam int PW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int LINE_BITS = OFFSET + $clog2(WORDS_PER_LINE);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Handshakes: a memory request is accepted on any cycle where mem_req && mem_ack;
    // each mem_rvalid pulse during BURST carries exactly one word, and core_rvalid
    // follows it one cycle later. No backpressure toward the cores.

    logic [1:0]           state;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        owner;
    logic [2:0]           word_cnt;
    logic [2:0]           start_word;

    logic                 arb_valid;
    logic [PW-1:0]        arb_idx;
    logic [DATA_SIZE-1:0] sel_addr;
    logic [DATA_SIZE-1:0] fill_addr;
    logic [2:0]           fill_start;
    logic [NUM_CORES-1:0] arb_onehot;
    logic [NUM_CORES-1:0] owner_onehot;
    logic [PW-1:0]        rr_next;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!arb_valid && core_req[(int'(rr_ptr) + i) % NUM_CORES]) begin
                arb_valid = 1'b1;
                arb_idx   = PW'((int'(rr_ptr) + i) % NUM_CORES);
            end
        end
    end

    always_comb begin
        sel_addr     = core_addr[arb_idx*DATA_SIZE +: DATA_SIZE];
        arb_onehot   = '0;
        arb_onehot[arb_idx] = 1'b1;
        owner_onehot = '0;
        owner_onehot[owner] = 1'b1;
        rr_next      = (owner == PW'(NUM_CORES - 1)) ? '0 : owner + 1'b1;
`ifdef CRITICAL_WORD_FIRST_EN
        fill_addr  = sel_addr & ~DATA_SIZE'((1 << OFFSET) - 1);
        fill_start = sel_addr[OFFSET +: 3];
`else
        fill_addr  = sel_addr & ~DATA_SIZE'((1 << LINE_BITS) - 1);
        fill_start = 3'd0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            word_cnt    <= '0;
            start_word  <= '0;
            core_gnt    <= '0;
            core_rdata  <= '0;
            core_rvalid <= '0;
            core_widx   <= '0;
            core_done   <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
        end else begin
            core_rvalid <= '0;
            core_done   <= '0;
            case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        owner      <= arb_idx;
                        core_gnt   <= arb_onehot;
                        mem_req    <= 1'b1;
                        mem_addr   <= fill_addr;
                        start_word <= fill_start;
                        state      <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        word_cnt <= '0;
                        state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (mem_rvalid) begin
                        core_rdata  <= mem_rdata;
                        core_rvalid <= owner_onehot;
                        core_widx   <= start_word + word_cnt;
                        word_cnt    <= word_cnt + 3'd1;
                        // Ends on the count so the 3-bit counter never relies on overflow.
                        if (word_cnt == 3'(WORDS_PER_LINE - 1)) begin
                            core_done <= owner_onehot;
                            state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    core_gnt <= '0;
                    rr_ptr   <= rr_next;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/line_fill_arbiter.md
Name: line_fill_arbiter

Overview:
- Shares one external memory read port among NUM_CORES per-core cache controllers that need line fills.
- Each fill is a burst of WORDS_PER_LINE = 8 words; a line is 32 bytes.
- Arbitration is round-robin, one burst at a time.
- Sits between the per-core instruction/data caches and the shared memory interface of the multicore processor.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8)
- DATA_SIZE, 32, word width in bits
- WORDS_PER_LINE, 8, words per line; burst length
- OFFSET, 2, byte-offset bits per word

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- core_req  in  NUM_CORES  per-core fill request; level-held until core_done
- core_addr  in  NUM_CORES*DATA_SIZE  per-core miss byte address, packed with core i at [i*32 +: 32]
- core_gnt  out  NUM_CORES  one-hot; high for the whole burst owned by that core
- core_rdata  out  DATA_SIZE  fill data, shared by all cores
- core_rvalid  out  NUM_CORES  one-hot; core_rdata is valid for that core this cycle
- core_widx  out  3  word index within the line for core_rdata
- core_done  out  NUM_CORES  one-cycle pulse on the last word of the burst
- mem_req  out  1  memory burst request
- mem_addr  out  DATA_SIZE  burst start address
- mem_ack  in  1  memory accepts request (mem_req && mem_ack)
- mem_rvalid  in  1  one returned word per pulse
- mem_rdata  in  DATA_SIZE  returned word

Behaviour:
- Reset: asynchronous and active-high. Every output resets to 0, state = IDLE, rr_ptr = 0, word_cnt = 0. Asserting rst mid-burst aborts the burst immediately. mem_rvalid pulses after reset deasserts are ignored until a new request is accepted.
- IDLE:
  - If any core_req is set, grant the first requester found searching from rr_ptr upward with wrap-around (modulo NUM_CORES).
  - Next cycle: core_gnt[g] = 1, mem_req = 1, mem_addr = core_addr[g] with bits [4:0] cleared (line aligned); go to ADDR.
  - Request-to-mem_req latency is 1 cycle.
- ADDR:
  - Hold mem_req and mem_addr stable until mem_ack.
  - On mem_ack: mem_req = 0 next cycle, word_cnt = 0, go to BURST.
  - core_req[g] deasserting here is ignored; the burst still completes.
- BURST:
  - Each mem_rvalid registers mem_rdata into core_rdata, core_rvalid[g] = 1 and core_widx = start_word + word_cnt (mod 8), then word_cnt increments.
  - Registered latency is 1 cycle after mem_rvalid.
  - Gaps between mem_rvalid pulses are allowed and produce no outputs.
  - On the 8th word: core_done[g] pulses together with that word's core_rvalid; go to DONE.
- DONE (1 cycle):
  - core_gnt = 0, rr_ptr = g+1 mod NUM_CORES, return to IDLE.
  - A core re-requesting immediately is rearbitrated with lowest priority.
  - Minimum gap between the last word of one burst and the next mem_req is 2 cycles.
- Simultaneous requests: only one grant; the others wait, with no starvation; worst-case wait is NUM_CORES-1 bursts.
- core_addr changes while that core is granted are ignored; the address is captured at grant.
- mem_rvalid in IDLE or ADDR is ignored.
- word_cnt is 3 bits; the burst ends on the count, not on overflow.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined:
  - mem_addr keeps bits [4:2] of the miss address (bits [1:0] cleared).
  - start_word = core_addr[g][4:2]; memory returns the words wrap-around starting there.
  - core_widx runs start_word, start_word+1, ... wrapping mod 8.
- Undefined:
  - mem_addr is line aligned and start_word = 0, so core_widx runs 0..7.
- In both cases core_done fires after exactly 8 words.

Test Plan:
- Single request: core_req=0001, core_addr[0]=0x0000_1234, mem_ack after 2 cycles, 8 contiguous mem_rvalid with data 0xA0..0xA7.
  - Expect mem_addr=0x0000_1220, core_rvalid[0] 8 times, core_widx 0..7, core_done[0] with data 0xA7.
- Simultaneous core_req=1111 from reset → grants in order core 0,1,2,3, each after the prior core_done plus the DONE cycle; rr_ptr ends at 0.
- Fairness: core 0 re-requests immediately after its done while core 2 is waiting → core 2 is granted before core 0.
- Gapped data: mem_rvalid on cycles 0,3,4,9,10,11,15,20 → exactly 8 core_rvalid pulses, each one cycle after the input; core_done on the last.
- Reset at word 4 of a burst → all outputs 0 asynchronously; after release, core_req=0010 starts a clean burst with core_widx from 0.
- CRITICAL_WORD_FIRST_EN defined, core_addr=0x0000_1234 → mem_addr=0x0000_1234, core_widx sequence 5,6,7,0,1,2,3,4.
